detector_pulsacion: RTL

DETECTOR_PULSACION -- requirements
Module: detector_pulsacion

---
 rtl/detector_pulsacion.sv | 80 ++++++++
 1 files changed

// File: rtl/detector_pulsacion.sv
// detector_pulsacion: press/release/long-press/auto-repeat event generator for a debounced button
module detector_pulsacion #(
  parameter int CNT_W    = 25,
  parameter int LONG_CYC = 25000000,
  parameter int REP_CYC  = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic press,
  output logic released,
  output logic long,
  output logic rep,
  output logic held
);
  typedef enum logic [1:0] {IDLE, PRESS, LONG} state_t;
  localparam logic [CNT_W-1:0] LONG_END = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_END  = CNT_W'(REP_CYC - 1);
  state_t state;
  logic [CNT_W-1:0] cnt;
  // release on the terminal-count edge wins, so long/rep only fire while in stays high
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      press    <= 1'b0;
      released <= 1'b0;
      long     <= 1'b0;
      rep      <= 1'b0;
      held     <= 1'b0;
    end else begin
      press    <= 1'b0;
      released <= 1'b0;
      long     <= 1'b0;
      rep      <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (in) begin
            state <= PRESS;
            press <= 1'b1;
            held  <= 1'b1;
          end
        end
        PRESS: begin
          if (!in) begin
            state    <= IDLE;
            cnt      <= '0;
            released <= 1'b1;
            held     <= 1'b0;
          end else if (cnt == LONG_END) begin
            state <= LONG;
            cnt   <= '0;
            long  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LONG: begin
          if (!in) begin
            state    <= IDLE;
            cnt      <= '0;
            released <= 1'b1;
            held     <= 1'b0;
          end else if (cnt == REP_END) begin
            cnt <= '0;
            rep <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end
endmodule
